// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main controller:
// opcodes, FSM states, datapath select encodings and the control bundle.
package mips_ctrl_pkg;

  localparam int unsigned OPCODE_W = 6;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
  } state_t;

  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10} alu_op_t;
  typedef enum logic [1:0] {SRCB_B = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11} srcb_t;
  typedef enum logic [1:0] {PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10} pcsrc_t;

  typedef struct packed {
    logic    iord;
    logic    mem_write;
    logic    ir_write;
    logic    reg_dst;
    logic    mem_to_reg;
    logic    reg_write;
    logic    alu_src_a;
    srcb_t   alu_src_b;
    alu_op_t alu_op;
    pcsrc_t  pc_src;
    logic    branch;
    logic    pc_write;
    logic    instr_done;
  } ctrl_t;

  // Moore output decode; any encoding outside the enum drives FETCH outputs.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_DECODE: c.alu_src_b = SRCB_IMM_SH2;
      S_MEMADR, S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: c.iord = 1'b1;
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEMWR: begin
        c.iord       = 1'b1;
        c.mem_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = 1'b1;
        c.instr_done = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a  = 1'b1;
        c.alu_op     = ALU_SUB;
        c.pc_src     = PC_ALUOUT;
        c.branch     = 1'b1;
        c.instr_done = 1'b1;
      end
      S_ADDIWB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_JUMP: begin
        c.pc_src     = PC_JUMP;
        c.pc_write   = 1'b1;
        c.instr_done = 1'b1;
      end
      default: begin
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/main_control_fsm.sv
// Multi-cycle MIPS main controller: sequences fetch/decode/execute/memory/
// writeback from the IR opcode and drives Moore datapath controls.
module main_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output logic                    IorD,
  output logic                    MemWrite,
  output logic                    IRWrite,
  output logic                    RegDst,
  output logic                    MemtoReg,
  output logic                    RegWrite,
  output logic                    ALUSrcA,
  output logic [1:0]              ALUSrcB,
  output logic [1:0]              ALUOp,
  output logic [1:0]              PCSrc,
  output logic                    Branch,
  output logic                    PCWrite,
  output logic                    instr_done
);

  state_t state, next_state;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH: next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JUMP;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEMADR: next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next_state = S_MEMWB;
      S_EXEC:   next_state = S_ALUWB;
      S_ADDIEX: next_state = S_ADDIWB;
      default:  next_state = S_FETCH;
    endcase
  end

  // Reset gates every output combinationally so nothing writes while rst_n is low.
  assign ctrl = rst_n ? state_ctrl(state) : '0;

  assign IorD       = ctrl.iord;
  assign MemWrite   = ctrl.mem_write;
  assign IRWrite    = ctrl.ir_write;
  assign RegDst     = ctrl.reg_dst;
  assign MemtoReg   = ctrl.mem_to_reg;
  assign RegWrite   = ctrl.reg_write;
  assign ALUSrcA    = ctrl.alu_src_a;
  assign ALUSrcB    = ctrl.alu_src_b;
  assign ALUOp      = ctrl.alu_op;
  assign PCSrc      = ctrl.pc_src;
  assign Branch     = ctrl.branch;
  assign PCWrite    = ctrl.pc_write;
  assign instr_done = ctrl.instr_done;

endmodule

// File: tb/tb_main_control_fsm.sv
// Self-checking bench: per-instruction cycle-by-cycle control expectations
// computed from the instruction-level microcode table, with randomized opcodes.
module tb_main_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       Branch, PCWrite, instr_done;

  int passed = 0;
  int total  = 0;

  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] J     = 6'b000010;

  always #5 clk = ~clk;

  main_control_fsm #(.OPCODE_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .Branch(Branch),
    .PCWrite(PCWrite), .instr_done(instr_done)
  );

  // {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSrc,Branch,PCWrite,instr_done}
  logic [15:0] obs;
  assign obs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                ALUSrcB, ALUOp, PCSrc, Branch, PCWrite, instr_done};

  function automatic logic [15:0] pk(input logic iord, mw, irw, rd, m2r, rw, sa,
                                     input logic [1:0] sb, aop, pcs,
                                     input logic br, pcw, done);
    return {iord, mw, irw, rd, m2r, rw, sa, sb, aop, pcs, br, pcw, done};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {RTYPE, LW, SW, BEQ, ADDI, J};
  endfunction

  function automatic int cycles_for(input logic [5:0] op);
    case (op)
      LW:                   return 5;
      SW, RTYPE, ADDI:      return 4;
      BEQ, J:               return 3;
      default:              return 2;
    endcase
  endfunction

  // Expected controls in cycle k (0-based) of an instruction with opcode op.
  function automatic logic [15:0] expected(input logic [5:0] op, input int k);
    if (k == 0) return pk(0,0,1,0,0,0,0, 2'b01, 2'b00, 2'b00, 0,1,0);
    if (k == 1) return pk(0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 0,0,0);
    case (op)
      LW: case (k)
        2: return pk(0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0,0,0);
        3: return pk(1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0,0);
        default: return pk(0,0,0,0,1,1,0, 2'b00, 2'b00, 2'b00, 0,0,1);
      endcase
      SW: if (k == 2) return pk(0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0,0,0);
          else        return pk(1,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0,1);
      RTYPE: if (k == 2) return pk(0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00, 0,0,0);
             else        return pk(0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00, 0,0,1);
      ADDI: if (k == 2) return pk(0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0,0,0);
            else        return pk(0,0,0,0,0,1,0, 2'b00, 2'b00, 2'b00, 0,0,1);
      BEQ: return pk(0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 1,0,1);
      J:   return pk(0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10, 0,1,1);
      default: return '0;
    endcase
  endfunction

  function automatic logic [5:0] random_illegal();
    logic [5:0] op;
    op = 6'($urandom);
    while (is_legal(op)) op = 6'($urandom);
    return op;
  endfunction

  // Called at a sample point (#1 after posedge) where the instruction's FETCH is expected.
  // opcode holds the real value only where it is sampled; elsewhere it is noise.
  task automatic run_instr(input logic [5:0] op, input string tag, input int stop_at = 99);
    int n;
    n = cycles_for(op);
    if (stop_at < n) n = stop_at;
    for (int k = 0; k < n; k++) begin
      total++;
      if (obs !== expected(op, k))
        $display("FAIL %s op=%b cycle %0d: got %h expected %h", tag, op, k, obs, expected(op, k));
      else passed++;
      if (k == 1 || (k == 2 && (op == LW || op == SW))) opcode = op;
      else opcode = 6'($urandom);
      if (k != n - 1 || stop_at >= 99) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    opcode = LW;
    repeat (2) begin
      @(posedge clk); #1;
      total++;
      if (obs !== 16'h0) $display("FAIL reset_outputs: got %h expected %h", obs, 16'h0);
      else passed++;
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (obs !== expected(LW, 0))
      $display("FAIL reset_release_fetch: got %h expected %h", obs, expected(LW, 0));
    else passed++;
  endtask

  task automatic test_lw();            run_instr(LW, "lw"); endtask
  task automatic test_back_to_back();  run_instr(RTYPE, "b2b_rtype"); run_instr(SW, "b2b_sw"); endtask
  task automatic test_branch_jump();   run_instr(BEQ, "beq"); run_instr(J, "jump"); endtask
  task automatic test_illegal();       run_instr(6'b111111, "illegal"); run_instr(ADDI, "addi_after_illegal"); endtask

  task automatic test_reset_mid_instr();
    run_instr(LW, "lw_abort", 4);      // stops at the MEMRD sample point
    rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 16'h0) $display("FAIL abort_gated: got %h expected %h", obs, 16'h0);
    else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    total++;
    if (obs !== expected(LW, 0) || RegWrite !== 1'b0)
      $display("FAIL abort_refetch: got %h expected %h", obs, expected(LW, 0));
    else passed++;
    run_instr(LW, "lw_after_abort");
  endtask

  task automatic test_random();
    logic [5:0] legal [6] = '{RTYPE, LW, SW, BEQ, ADDI, J};
    logic [5:0] op;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 6) == 0) op = random_illegal();
      else op = legal[$urandom_range(0, 5)];
      run_instr(op, "random");
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_back_to_back();
    test_branch_jump();
    test_illegal();
    test_reset_mid_instr();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
